// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO, STATUS/BAUD/CTRL/LEVEL/ID registers.
// Optional parity bit (CTRL[3:2]) is built only when UART_TX_PARITY_EN is defined.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'hE000_0000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [31:0]   ID_VALUE = 32'h5541_5254;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  // Register file
  logic [3:0]    ctrl_q, ctrl_d;
  logic [15:0]   baud_q, baud_d;
  logic          ovf_q, ovf_d;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  // Serialiser
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   eff_div_q, eff_div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic          par_bit_q, par_bit_d;
  logic          par_en_q, par_en_d;
`endif

  // Registered outputs
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          irq_q, irq_d;

  logic [2:0]    reg_idx;
  logic          wr_en;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          bit_done;
  logic          unused_bits;

  assign reg_idx     = addr[4:2];
  assign sel         = (addr[31:5] == BASE_ADDR[31:5]) && (addr[4:0] < 5'h18);
  assign wr_en       = mem_write && sel;
  assign push_req    = wr_en && (reg_idx == 3'd0);
  assign full        = (level_q == DEPTH_L);
  assign empty       = (level_q == '0);
  assign push        = push_req && !full;
  assign pop         = (state_q == S_IDLE) && ctrl_q[0] && !empty;
  assign bit_done    = (cnt_q == (eff_div_q - 16'd1));
  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  assign tx  = tx_q;
  assign irq = irq_q;

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (reg_idx)
        3'd1:    rdata = {27'b0, ovf_q, full, empty, busy_q, ctrl_q[0]};
        3'd2:    rdata = {16'b0, baud_q};
        3'd3:    rdata = {28'b0, ctrl_q};
        3'd4:    rdata = {{(32 - LW){1'b0}}, level_q};
        3'd5:    rdata = ID_VALUE;
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    baud_d    = baud_q;
    ovf_d     = ovf_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    eff_div_d = eff_div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
`endif

    if (wr_en) begin
      unique case (reg_idx)
        3'd1: if (wdata[4]) ovf_d = 1'b0;
        3'd2: baud_d = wdata[15:0];
`ifdef UART_TX_PARITY_EN
        3'd3: ctrl_d = wdata[3:0];
`else
        3'd3: ctrl_d = {2'b00, wdata[1:0]};
`endif
        default: ;
      endcase
    end

    if (push_req && full) ovf_d = 1'b1;

    if (push) begin
      mem_d[wr_ptr_q] = wdata[7:0];
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q];
          eff_div_d = (baud_q == '0) ? 16'd1 : baud_q;
          cnt_d     = '0;
          bit_d     = '0;
`ifdef UART_TX_PARITY_EN
          par_bit_d = (^mem_q[rd_ptr_q]) ^ ctrl_q[3];
          par_en_d  = ctrl_q[2];
`endif
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so tx and busy trail the FSM by one clock.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_bit_q;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_q != S_IDLE);
    irq_d  = empty && (state_q == S_IDLE) && ctrl_q[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      baud_q    <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      eff_div_q <= 16'd1;
      bit_q     <= '0;
      shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
`endif
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      baud_q    <= baud_d;
      ovf_q     <= ovf_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      eff_div_q <= eff_div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
`ifdef UART_TX_PARITY_EN
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
`endif
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed and randomized frames checked against a slot-timing line model.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX = 32'hE000_0000;
  localparam logic [31:0] A_ST = 32'hE000_0004;
  localparam logic [31:0] A_BD = 32'hE000_0008;
  localparam logic [31:0] A_CT = 32'hE000_000C;
  localparam logic [31:0] A_LV = 32'hE000_0010;
  localparam logic [31:0] A_ID = 32'hE000_0014;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [31:0] rdata;
  logic        sel;
  logic        tx;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int t0          = 0;
  int n_fr        = 0;

  // Expected frames, queued in transmit order starting at k=2 after t0.
  logic [7:0] fr_byte [16];
  int         fr_div  [16];
  logic       fr_pen  [16];
  logic       fr_par  [16];

  mmio_uart_tx #(
    .BASE_ADDR  (32'hE000_0000),
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .mem_write(mem_write),
    .rdata    (rdata),
    .sel      (sel),
    .tx       (tx),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    addr      = A_ST;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
    addr = A_ST;
  endtask

  task automatic add_frame(input logic [7:0] b, input int div, input logic pen, input logic odd);
    fr_byte[n_fr] = b;
    fr_div[n_fr]  = div;
    fr_pen[n_fr]  = pen;
    fr_par[n_fr]  = ($countones(b) % 2 == 1) ^ odd;
    n_fr++;
  endtask

  // Line model: each frame is start + 8 data (+ parity) + stop slots of div clocks,
  // frames back to back with a single idle clock between them.
  task automatic model(input int k, output logic etx, output logic ebusy);
    int s;
    int len;
    int slot;
    s     = 2;
    etx   = 1'b1;
    ebusy = 1'b0;
    for (int i = 0; i < n_fr; i++) begin
      len = (fr_pen[i] ? 11 : 10) * fr_div[i];
      if (k >= s && k < s + len) begin
        ebusy = 1'b1;
        slot  = (k - s) / fr_div[i];
        if (slot == 0)                     etx = 1'b0;
        else if (slot <= 8)                etx = fr_byte[i][slot-1];
        else if (fr_pen[i] && slot == 9)   etx = fr_par[i];
        else                               etx = 1'b1;
      end
      s = s + len + 1;
    end
  endtask

  task automatic check_wave(input int n, input string tag);
    logic etx;
    logic ebusy;
    addr = A_ST;
    repeat (n) begin
      tick();
      model(cyc - t0, etx, ebusy);
      chk({tag, "_tx"},   {31'b0, tx},       {31'b0, etx});
      chk({tag, "_busy"}, {31'b0, rdata[1]}, {31'b0, ebusy});
    end
  endtask

  initial begin
    logic [7:0]  b [9];
    logic [7:0]  rb;
    int          div;
    int          nb;
    logic        pen;
    logic        odd;
    logic [31:0] cw;

    rst       = 1'b1;
    mem_write = 1'b0;
    addr      = A_ST;
    wdata     = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state and decode window
    chk("rst_tx",  {31'b0, tx},  32'd1);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    rd_chk("rst_status", A_ST, 32'h4);
    rd_chk("rst_baud",   A_BD, 32'd16);
    rd_chk("rst_ctrl",   A_CT, 32'd0);
    rd_chk("rst_level",  A_LV, 32'd0);
    rd_chk("rst_id",     A_ID, 32'h5541_5254);
    rd_chk("id_alias",   32'hE000_0017, 32'h5541_5254);
    rd_chk("out_0x18",   32'hE000_0018, 32'd0);
    addr = 32'hE000_0018; #1; chk("sel_0x18", {31'b0, sel}, 32'd0);
    addr = 32'hE000_0014; #1; chk("sel_0x14", {31'b0, sel}, 32'd1);
    addr = 32'hE001_0004; #1; chk("sel_hi",   {31'b0, sel}, 32'd0);
    bus_write(32'hE000_0020, 32'hAA);
    rd_chk("no_push_outside", A_LV, 32'd0);

    // Single byte at default divisor: start low at T+2, busy clears at T+162
    bus_write(A_CT, 32'h1);
    n_fr = 0;
    add_frame(8'h48, 16, 1'b0, 1'b0);
    bus_write(A_TX, 32'h48);
    t0 = cyc - 1;
    t0 = cyc;
    check_wave(170, "t2");

    // Overflow, ovf clear, then drain the first 8 bytes in order
    bus_write(A_CT, 32'h0);
    for (int i = 0; i < 9; i++) begin
      b[i] = 8'($urandom);
      bus_write(A_TX, {24'b0, b[i]});
      rd_chk("fill_level", A_LV, (i < 8) ? (i + 1) : 8);
    end
    rd_chk("full_status", A_ST, 32'h18);
    bus_write(A_ST, 32'h10);
    rd_chk("ovf_clear", A_ST, 32'h08);
    bus_write(A_BD, 32'd2);
    n_fr = 0;
    for (int i = 0; i < 8; i++) add_frame(b[i], 2, 1'b0, 1'b0);
    bus_write(A_CT, 32'h1);
    t0 = cyc;
    check_wave(8 * 21 + 4, "drain");
    rd_chk("drain_level", A_LV, 32'd0);

    // Interrupt level
    bus_write(A_CT, 32'h3);
    tick();
    chk("irq_on", {31'b0, irq}, 32'd1);
    bus_write(A_CT, 32'h1);
    tick();
    chk("irq_off", {31'b0, irq}, 32'd0);

    // BAUD_DIV=0 gives 1-clock bits; a mid-frame write applies from the next frame
    bus_write(A_BD, 32'd0);
    b[0] = 8'($urandom);
    b[1] = 8'($urandom);
    n_fr = 0;
    add_frame(b[0], 1, 1'b0, 1'b0);
    add_frame(b[1], 3, 1'b0, 1'b0);
    bus_write(A_TX, {24'b0, b[0]});
    t0 = cyc;
    bus_write(A_TX, {24'b0, b[1]});
    bus_write(A_BD, 32'd3);
    check_wave(10 + 1 + 30 + 6, "div");

    // Clearing enable mid-frame finishes the frame and stops popping
    bus_write(A_BD, 32'd1);
    b[0] = 8'($urandom);
    b[1] = 8'($urandom);
    n_fr = 0;
    add_frame(b[0], 1, 1'b0, 1'b0);
    bus_write(A_TX, {24'b0, b[0]});
    t0 = cyc;
    bus_write(A_TX, {24'b0, b[1]});
    bus_write(A_CT, 32'h0);
    check_wave(20, "dis");
    rd_chk("dis_level", A_LV, 32'd1);
    n_fr = 0;
    add_frame(b[1], 1, 1'b0, 1'b0);
    bus_write(A_CT, 32'h1);
    t0 = cyc;
    check_wave(14, "reen");

    // Randomized rounds: divisor, byte count, data and (when built) parity mode
    repeat (4) begin
      div = $urandom_range(1, 5);
      nb  = $urandom_range(1, 3);
`ifdef UART_TX_PARITY_EN
      pen = 1'($urandom_range(0, 1));
      odd = 1'($urandom_range(0, 1));
`else
      pen = 1'b0;
      odd = 1'b0;
`endif
      cw = {28'b0, odd, pen, 2'b01};
      bus_write(A_CT, cw);
      bus_write(A_BD, div);
      n_fr = 0;
      for (int i = 0; i < nb; i++) begin
        rb = 8'($urandom);
        add_frame(rb, div, pen, odd);
        bus_write(A_TX, {24'b0, rb});
        if (i == 0) t0 = cyc;
      end
      check_wave(nb * (11 * div + 1) + 4 - (nb - 1), "rnd");
    end
    bus_write(A_CT, 32'h1);

    // Synchronous reset during the data bits abandons the frame and flushes the FIFO
    bus_write(A_BD, 32'd4);
    n_fr = 0;
    add_frame(8'h55, 4, 1'b0, 1'b0);
    bus_write(A_TX, 32'h55);
    t0 = cyc;
    bus_write(A_TX, 32'hA5);
    check_wave(13, "pre_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_tx", {31'b0, tx}, 32'd1);
    rd_chk("mid_rst_level",  A_LV, 32'd0);
    rd_chk("mid_rst_status", A_ST, 32'h4);
    rd_chk("mid_rst_baud",   A_BD, 32'd16);
    n_fr = 0;
    check_wave(20, "post_rst");

    // CTRL[3:2] readback depends on the build
    bus_write(A_CT, 32'hF);
`ifdef UART_TX_PARITY_EN
    rd_chk("ctrl_rb", A_CT, 32'hF);
`else
    rd_chk("ctrl_rb", A_CT, 32'h3);
`endif
    bus_write(A_CT, 32'h0);

`ifdef UART_TX_PARITY_EN
    // Even parity of 0x07 is 1, odd parity is 0
    bus_write(A_BD, 32'd2);
    bus_write(A_CT, 32'h5);
    n_fr = 0;
    add_frame(8'h07, 2, 1'b1, 1'b0);
    bus_write(A_TX, 32'h07);
    t0 = cyc;
    check_wave(26, "par_even");
    chk("par_even_bit", {31'b0, fr_par[0]}, 32'd1);
    bus_write(A_CT, 32'hD);
    n_fr = 0;
    add_frame(8'h07, 2, 1'b1, 1'b1);
    bus_write(A_TX, 32'h07);
    t0 = cyc;
    check_wave(26, "par_odd");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
